// File: rtl/spi_reg_ctrl_if.sv
// Bus bundle between the SPI byte receiver, spi_reg_ctrl and the register bank.
// slave = controller view, master = receiver/bank (environment) view.
interface spi_reg_ctrl_if #(
   parameter int unsigned ADDR_W = 4
) ();
   logic              cs_s;
   logic [7:0]        rx_data;
   logic              rx_val;
   logic              rx_rdy;
   logic [7:0]        tx_data;
   logic              tx_load;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wdata;
   logic              reg_we;
   logic [7:0]        reg_rdata;
   logic              busy;
   logic              err;

   modport slave (
      input  cs_s, rx_data, rx_val, reg_rdata,
      output rx_rdy, tx_data, tx_load, reg_addr, reg_wdata, reg_we, busy, err
   );

   modport master (
      output cs_s, rx_data, rx_val, reg_rdata,
      input  rx_rdy, tx_data, tx_load, reg_addr, reg_wdata, reg_we, busy, err
   );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder: command / address / data-burst sequencing onto a byte register bank.
// SPI_REG_AUTOINC_EN: when defined, reg_addr auto-increments through a burst.
module spi_reg_ctrl #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   spi_reg_ctrl_if.slave    bus
);

`ifdef SPI_REG_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      RFETCH,
      RDATA,
      DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic              wr_mode_q, wr_mode_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_load_q, tx_load_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]        reg_wdata_q, reg_wdata_d;
   logic              reg_we_q, reg_we_d;
   logic              err_q, err_d;

   logic              rx_rdy;
   logic              hs;
   logic              rd_load;

   assign rx_rdy  = (state_q != RFETCH);
   assign hs      = bus.rx_val & rx_rdy;
   // Read data only settles in the cycle RDATA is entered, so it is passed straight
   // through on the load cycle and held in tx_data_q from then on.
   assign rd_load = (state_q == RDATA) && tx_load_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_mode_q   <= 1'b0;
         tx_data_q   <= '0;
         tx_load_q   <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_mode_q   <= wr_mode_d;
         tx_data_q   <= tx_data_d;
         tx_load_q   <= tx_load_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_mode_d   = wr_mode_q;
      tx_data_d   = tx_data_q;
      tx_load_d   = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      err_d       = err_q;

      if (rd_load) begin
         tx_data_d = bus.reg_rdata;
      end
      // Write-burst address advances the cycle after the strobe, even across an abort.
      if (AUTOINC && reg_we_q) begin
         reg_addr_d = reg_addr_q + ADDR_ONE;
      end

      if (bus.cs_s) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (hs) begin
                  case (bus.rx_data)
                     8'h01: begin
                        wr_mode_d = 1'b1;
                        state_d   = ADDR;
                     end
                     8'h02: begin
                        wr_mode_d = 1'b0;
                        state_d   = ADDR;
                     end
                     8'h03: begin
                        tx_data_d = {7'd0, err_q};
                        tx_load_d = 1'b1;
                        err_d     = 1'b0;
                        state_d   = DRAIN;
                     end
                     default: begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                     end
                  endcase
               end
            end
            ADDR: begin
               if (hs) begin
                  if ((bus.rx_data >> ADDR_W) != 8'd0) begin
                     err_d   = 1'b1;
                     state_d = DRAIN;
                  end else begin
                     reg_addr_d = bus.rx_data[ADDR_W-1:0];
                     state_d    = wr_mode_q ? WDATA : RFETCH;
                  end
               end
            end
            WDATA: begin
               if (hs) begin
                  reg_wdata_d = bus.rx_data;
                  reg_we_d    = 1'b1;
               end
            end
            RFETCH: begin
               tx_load_d = 1'b1;
               state_d   = RDATA;
            end
            RDATA: begin
               if (hs) begin
                  if (AUTOINC) begin
                     reg_addr_d = reg_addr_q + ADDR_ONE;
                  end
                  state_d = RFETCH;
               end
            end
            DRAIN: begin
               state_d = DRAIN;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.rx_rdy    = rx_rdy;
   assign bus.tx_data   = rd_load ? bus.reg_rdata : tx_data_q;
   assign bus.tx_load   = tx_load_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: vector table of bursts, scoreboarded
// reg_we / tx_load events, plus hand-written error, abort and reset sequences.
module tb_spi_reg_ctrl;

`ifdef SPI_REG_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic clk;
   logic rst;

   spi_reg_ctrl_if #(.ADDR_W(4)) bus ();

   spi_reg_ctrl #(.ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_wr[$];
   logic [7:0] exp_tx[$];

   // Environment register bank: synchronous read, one cycle after reg_addr.
   logic [7:0] bank [16];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) bank[i] <= 8'h00;
         bank[5] <= 8'h5A;
         bank[6] <= 8'hC3;
      end else if (bus.reg_we) begin
         bank[bus.reg_addr] <= bus.reg_wdata;
      end
      bus.reg_rdata <= bank[bus.reg_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.reg_we && bus.tx_load) begin
            checks++;
            errors++;
            $display("FAIL we_load_overlap: reg_we=1 tx_load=1 expected never both at %0t", $time);
         end
         if (bus.reg_we) begin
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_we: addr 0x%0h data 0x%0h expected no write at %0t",
                        bus.reg_addr, bus.reg_wdata, $time);
            end else begin
               wr_t w;
               w = exp_wr.pop_front();
               chk("sb_we_addr", 32'(bus.reg_addr), 32'(w.addr));
               chk("sb_we_data", 32'(bus.reg_wdata), 32'(w.data));
            end
         end
         if (bus.tx_load) begin
            if (exp_tx.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_load: tx_data 0x%0h expected no load at %0t",
                        bus.tx_data, $time);
            end else begin
               logic [7:0] t;
               t = exp_tx.pop_front();
               chk("sb_tx_data", 32'(bus.tx_data), 32'(t));
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
   task automatic send(input logic [7:0] b);
      int unsigned n;
      n = 0;
      bus.rx_data = b;
      bus.rx_val  = 1'b1;
      while (!bus.rx_rdy && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.rx_rdy) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: rx_rdy stuck 0 expected 1 for byte 0x%0h", b);
      end else begin
         @(posedge clk);
         #1;
      end
      bus.rx_val = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic end_frame();
      bus.cs_s = 1'b1;
      @(posedge clk);
      #1;
      chk("frame_idle_busy", 32'(bus.busy), 32'd0);
   endtask

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [3:0] ea0;
      logic [3:0] ea1;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t expected done", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // wr=1: b0/b1 are data bytes, ea0/ea1 the expected write addresses.
      // wr=0: b0/b1 are the expected MISO bytes for the first and post-dummy reads.
      vecs[0] = '{wr: 1'b0, addr: 8'h05, b0: 8'h5A, b1: (AUTOINC ? 8'hC3 : 8'h5A), ea0: 4'h0, ea1: 4'h0};
      vecs[1] = '{wr: 1'b1, addr: 8'h03, b0: 8'hAA, b1: 8'hBB, ea0: 4'h3, ea1: (AUTOINC ? 4'h4 : 4'h3)};
      vecs[2] = '{wr: 1'b1, addr: 8'h0F, b0: 8'h11, b1: 8'h22, ea0: 4'hF, ea1: (AUTOINC ? 4'h0 : 4'hF)};
      vecs[3] = '{wr: 1'b0, addr: 8'h03, b0: (AUTOINC ? 8'hAA : 8'hBB), b1: 8'hBB, ea0: 4'h0, ea1: 4'h0};
      vecs[4] = '{wr: 1'b0, addr: 8'h0F, b0: (AUTOINC ? 8'h11 : 8'h22), b1: 8'h22, ea0: 4'h0, ea1: 4'h0};

      rst         = 1'b1;
      bus.cs_s    = 1'b1;
      bus.rx_val  = 1'b0;
      bus.rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_tx_data",   32'(bus.tx_data),   32'd0);
      chk("rst_tx_load",   32'(bus.tx_load),   32'd0);
      chk("rst_reg_addr",  32'(bus.reg_addr),  32'd0);
      chk("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
      chk("rst_reg_we",    32'(bus.reg_we),    32'd0);
      chk("rst_err",       32'(bus.err),       32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_rx_rdy",    32'(bus.rx_rdy),    32'd1);

      // Command while deselected is dropped.
      send(8'h01);
      chk("cs_high_cmd_busy", 32'(bus.busy), 32'd0);

      for (int i = 0; i < 5; i++) begin
         bus.cs_s = 1'b0;
         if (vecs[i].wr) begin
            send(8'h01);
            send(vecs[i].addr);
            exp_wr.push_back('{addr: vecs[i].ea0, data: vecs[i].b0});
            send(vecs[i].b0);
            chk("wr0_we",    32'(bus.reg_we),    32'd1);
            chk("wr0_addr",  32'(bus.reg_addr),  32'(vecs[i].ea0));
            chk("wr0_wdata", 32'(bus.reg_wdata), 32'(vecs[i].b0));
            exp_wr.push_back('{addr: vecs[i].ea1, data: vecs[i].b1});
            send(vecs[i].b1);
            chk("wr1_we",    32'(bus.reg_we),    32'd1);
            chk("wr1_addr",  32'(bus.reg_addr),  32'(vecs[i].ea1));
            chk("wr1_wdata", 32'(bus.reg_wdata), 32'(vecs[i].b1));
            idle(2);
         end else begin
            send(8'h02);
            exp_tx.push_back(vecs[i].b0);
            send(vecs[i].addr);
            chk("rfetch_rdy",  32'(bus.rx_rdy),  32'd0);
            chk("rfetch_load", 32'(bus.tx_load), 32'd0);
            idle(1);
            chk("rd0_load", 32'(bus.tx_load), 32'd1);
            chk("rd0_data", 32'(bus.tx_data), 32'(vecs[i].b0));
            exp_tx.push_back(vecs[i].b1);
            send(8'hFF);
            chk("rd1_rdy", 32'(bus.rx_rdy), 32'd0);
            idle(1);
            chk("rd1_load", 32'(bus.tx_load), 32'd1);
            chk("rd1_data", 32'(bus.tx_data), 32'(vecs[i].b1));
            idle(1);
         end
         end_frame();
      end

      // Bad command: sticky error, remaining bytes drained.
      bus.cs_s = 1'b0;
      send(8'h7E);
      chk("badcmd_err",  32'(bus.err),  32'd1);
      chk("badcmd_busy", 32'(bus.busy), 32'd1);
      send(8'h01);
      send(8'h03);
      send(8'hAA);
      chk("drain_err", 32'(bus.err), 32'd1);
      end_frame();
      chk("err_survives_cs", 32'(bus.err), 32'd1);

      // Out-of-range address.
      bus.cs_s = 1'b0;
      send(8'h01);
      send(8'h20);
      chk("badaddr_err", 32'(bus.err), 32'd1);
      send(8'h55);
      send(8'h66);
      end_frame();

      // Status read returns and clears the error.
      bus.cs_s = 1'b0;
      exp_tx.push_back(8'h01);
      send(8'h03);
      chk("status_load", 32'(bus.tx_load), 32'd1);
      chk("status_data", 32'(bus.tx_data), 32'h01);
      chk("status_err",  32'(bus.err),     32'd0);
      end_frame();

      // cs_s rises together with a WDATA handshake: byte dropped.
      bus.cs_s = 1'b0;
      send(8'h01);
      send(8'h02);
      bus.rx_data = 8'h77;
      bus.rx_val  = 1'b1;
      bus.cs_s    = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_val = 1'b0;
      chk("abort_busy", 32'(bus.busy),   32'd0);
      chk("abort_we",   32'(bus.reg_we), 32'd0);
      idle(2);

      // Asynchronous reset during RFETCH.
      bus.cs_s = 1'b0;
      send(8'h02);
      send(8'h05);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_busy",   32'(bus.busy),     32'd0);
      chk("async_rst_addr",   32'(bus.reg_addr), 32'd0);
      chk("async_rst_rx_rdy", 32'(bus.rx_rdy),   32'd1);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      bus.cs_s = 1'b1;
      idle(3);
      chk("post_rst_load", 32'(bus.tx_load), 32'd0);

      chk("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
      chk("sb_tx_empty", 32'(exp_tx.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Command controller behind the SPI byte receiver. Consumes received bytes over a val/rdy handshake and decodes a 3-phase protocol: command, address, data burst. Sequences writes and reads on a register bank of 2**ADDR_W bytes and loads the next MISO byte for reads. Sits between the SPI receiver and the design's configuration register file.

Parameters:
ADDR_W, 4, register-bank address width; bank depth = 2**ADDR_W (16).

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
cs_s  in  1  chip-select already synchronised to clk, active-low (1 = bus idle)
rx_data  in  8  received byte from SPI receiver
rx_val  in  1  rx_data valid
rx_rdy  out  1  controller accepts rx_data; transfer when rx_val & rx_rdy
tx_data  out  8  next byte to shift out on MISO
tx_load  out  1  1-cycle pulse: tx_data is new
reg_addr  out  ADDR_W  register bank address
reg_wdata  out  8  register write data
reg_we  out  1  1-cycle write strobe
reg_rdata  in  8  register read data, valid 1 cycle after reg_addr (synchronous read)
busy  out  1  high in any state other than IDLE
err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst=1): state=IDLE; tx_data=0, tx_load=0, reg_addr=0, reg_wdata=0, reg_we=0, err=0, busy=0. rx_rdy=1 (IDLE accepts).
- rx_rdy = 1 in every state except RFETCH. A handshake consumes exactly one byte.
- States: IDLE, ADDR, WDATA, RFETCH, RDATA, DRAIN.
- IDLE, byte accepted (command):
  - 0x01 -> ADDR, write mode.
  - 0x02 -> ADDR, read mode.
  - 0x03 (status) -> tx_data={7'd0,err}, tx_load pulse next cycle, err cleared, -> DRAIN.
  - Any other value -> err=1, -> DRAIN.
- ADDR, byte accepted:
  - rx_data[7:ADDR_W]!=0 -> err=1, -> DRAIN.
  - Else reg_addr=rx_data[ADDR_W-1:0]; write mode -> WDATA, read mode -> RFETCH.
- WDATA, byte accepted at cycle N:
  - N+1: reg_wdata=byte, reg_we=1 for exactly one cycle at current reg_addr.
  - N+2: reg_addr advances (see Optional Feature).
  - Stays in WDATA; back-to-back bytes allowed every cycle.
- RFETCH: lasts one cycle (reg_rdata settling), -> RDATA with tx_data=reg_rdata and tx_load=1 in the same cycle RDATA is entered.
  - Read latency: address handshake at N -> tx_load at N+2.
- RDATA, byte accepted (dummy, value ignored): advance reg_addr, -> RFETCH (next byte preloaded 2 cycles later).
- DRAIN: accept and discard all bytes until cs_s=1.
- cs_s=1 in any state: next state IDLE; burst aborted; a byte handshaken in the same cycle is discarded, with no reg_we. err is not cleared. A reg_we already scheduled for this cycle still completes.
- Address wrap: 2**ADDR_W-1 advances to 0, with no error.
- Command received while cs_s=1: discarded, with no state change.
- tx_load and reg_we are never asserted in the same cycle.
- rst mid-burst: all state is lost immediately; no further reg_we.

Optional Feature:
SPI_REG_AUTOINC_EN.
- Defined: reg_addr increments (mod 2**ADDR_W) after each WDATA write and each RDATA dummy byte.
- Undefined: reg_addr holds its value for the whole burst (FIFO-style repeated access to one register). All other timing is unchanged.

Test Plan:
- Reset then idle: outputs all 0, rx_rdy=1, busy=0.
- Write burst: bytes 0x01,0x03,0xAA,0xBB with cs_s=0 -> reg_we at addr 3 data 0xAA, then addr 4 data 0xBB (with _EN; addr 3 both without).
- Read: bank[5]=0x5A, bank[6]=0xC3; bytes 0x02,0x05 -> tx_load with tx_data=0x5A 2 cycles after address handshake; rx_rdy=0 during RFETCH; one dummy byte -> tx_data=0xC3.
- Wrap: write 0x01,0x0F,0x11,0x22 -> writes to addr 15 then addr 0.
- Errors: cmd 0x7E -> err=1, later bytes dropped until cs_s=1. Then 0x01,0x20 -> err stays 1, no reg_we. Then status cmd 0x03 -> tx_data=0x01, err=0.
- Abort: cs_s rises in the same cycle as a WDATA handshake -> no reg_we, state IDLE next cycle; async rst mid-read -> busy=0 immediately.
